// File: rtl/mc_control_unit.sv
// mc_control_unit: multi-cycle FETCH->DECODE->EXEC->WB control sequencer for the
// reduced RISC-V datapath. The instruction word is decoded as it is accepted, so
// the control outputs and the illegal pulse are already valid during DECODE.
// Every output is registered and is computed from the state being entered.
// Optional feature macro: ALU_SLT_EN adds slti/slt (ALUctrl=101); when the macro
// is undefined both encodings decode as illegal.
module mc_control_unit #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDRESS_WIDTH  = 3,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic                      EQ,
    output logic [ADDRESS_WIDTH-1:0]  ALUctrl,
    output logic                      ALUsrc,
    output logic [DATA_WIDTH-1:0]     ImmOp,
    output logic [REG_ADDR_WIDTH-1:0] rs1,
    output logic [REG_ADDR_WIDTH-1:0] rs2,
    output logic [REG_ADDR_WIDTH-1:0] rd,
    output logic                      RegWrite,
    output logic                      PCsrc,
    output logic                      pc_en,
    output logic                      illegal,
    output logic                      busy
);

    typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [ADDRESS_WIDTH-1:0] ALU_ADD = ADDRESS_WIDTH'(0);
    localparam logic [ADDRESS_WIDTH-1:0] ALU_SUB = ADDRESS_WIDTH'(1);
    localparam logic [ADDRESS_WIDTH-1:0] ALU_AND = ADDRESS_WIDTH'(2);
    localparam logic [ADDRESS_WIDTH-1:0] ALU_OR  = ADDRESS_WIDTH'(3);
`ifdef ALU_SLT_EN
    localparam logic [ADDRESS_WIDTH-1:0] ALU_SLT = ADDRESS_WIDTH'(5);
`endif

    state_t state, next_state;

    logic                      handshake;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic signed [DATA_WIDTH-1:0] imm_i;
    logic signed [DATA_WIDTH-1:0] imm_b;

    logic                      dec_legal;
    logic [ADDRESS_WIDTH-1:0]  dec_ctrl;
    logic                      dec_src;
    logic [DATA_WIDTH-1:0]     dec_imm;
    logic [REG_ADDR_WIDTH-1:0] dec_rs1;
    logic [REG_ADDR_WIDTH-1:0] dec_rs2;
    logic [REG_ADDR_WIDTH-1:0] dec_rd;
    logic                      dec_writes;
    logic                      dec_branch;
    logic                      dec_bne;

    // Decoded attributes of the accepted instruction, used in EXEC/WB
    logic                      op_writes;
    logic                      op_branch;
    logic                      op_bne;

    assign handshake = instr_valid && instr_ready;
    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{(DATA_WIDTH-12){instr[31]}}, instr[31:20]};
    assign imm_b     = {{(DATA_WIDTH-13){instr[31]}}, instr[31], instr[7],
                        instr[30:25], instr[11:8], 1'b0};

    // Instruction decode of the word presented on instr
    always_comb begin
        dec_legal  = 1'b0;
        dec_ctrl   = ALU_ADD;
        dec_src    = 1'b0;
        dec_imm    = '0;
        dec_rs1    = instr[19:15];
        dec_rs2    = '0;
        dec_rd     = '0;
        dec_writes = 1'b0;
        dec_branch = 1'b0;
        dec_bne    = 1'b0;
        case (opcode)
            OPC_OPIMM: begin
                dec_src    = 1'b1;
                dec_imm    = imm_i;
                dec_rd     = instr[11:7];
                dec_writes = 1'b1;
                case (funct3)
                    3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
                    3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                    3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
`ifdef ALU_SLT_EN
                    3'b010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT; end
`endif
                    default: dec_legal = 1'b0;
                endcase
            end
            OPC_OP: begin
                dec_rs2    = instr[24:20];
                dec_rd     = instr[11:7];
                dec_writes = 1'b1;
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'b000: begin dec_legal = 1'b1; dec_ctrl = ALU_ADD; end
                        3'b111: begin dec_legal = 1'b1; dec_ctrl = ALU_AND; end
                        3'b110: begin dec_legal = 1'b1; dec_ctrl = ALU_OR;  end
`ifdef ALU_SLT_EN
                        3'b010: begin dec_legal = 1'b1; dec_ctrl = ALU_SLT; end
`endif
                        default: dec_legal = 1'b0;
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'b000) begin
                    dec_legal = 1'b1;
                    dec_ctrl  = ALU_SUB;
                end
            end
            OPC_BRANCH: begin
                dec_ctrl   = ALU_SUB;
                dec_imm    = imm_b;
                dec_rs2    = instr[24:20];
                dec_branch = 1'b1;
                dec_bne    = funct3[0];
                dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FETCH;
        else     state <= next_state;
    end

    // Next-state logic; an illegal word (flagged during DECODE) skips EXEC/WB
    always_comb begin
        next_state = state;
        case (state)
            FETCH:   if (handshake) next_state = DECODE;
            DECODE:  next_state = illegal ? FETCH : EXEC;
            EXEC:    next_state = WB;
            WB:      next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    // Registered outputs: controls load on acceptance, strobes fire on entering WB
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_ready <= 1'b1;
            busy        <= 1'b0;
            ALUctrl     <= '0;
            ALUsrc      <= 1'b0;
            ImmOp       <= '0;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            RegWrite    <= 1'b0;
            PCsrc       <= 1'b0;
            pc_en       <= 1'b0;
            illegal     <= 1'b0;
            op_writes   <= 1'b0;
            op_branch   <= 1'b0;
            op_bne      <= 1'b0;
        end else begin
            instr_ready <= (next_state == FETCH);
            busy        <= (next_state != FETCH);
            illegal     <= (state == FETCH) && handshake && !dec_legal;
            if ((state == FETCH) && handshake && dec_legal) begin
                ALUctrl   <= dec_ctrl;
                ALUsrc    <= dec_src;
                ImmOp     <= dec_imm;
                rs1       <= dec_rs1;
                rs2       <= dec_rs2;
                rd        <= dec_rd;
                op_writes <= dec_writes;
                op_branch <= dec_branch;
                op_bne    <= dec_bne;
            end
            pc_en    <= (state == EXEC);
            RegWrite <= (state == EXEC) && op_writes && (rd != '0);
            PCsrc    <= (state == EXEC) && op_branch && (op_bne ? !EQ : EQ);
        end
    end

endmodule

// File: tb/tb_mc_control_unit.sv
// Testbench for mc_control_unit: directed vectors plus randomized instruction
// streams checked against a table-driven decode/timing reference model.
module tb_mc_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        EQ;
    logic [2:0]  ALUctrl;
    logic        ALUsrc;
    logic [31:0] ImmOp;
    logic [4:0]  rs1, rs2, rd;
    logic        RegWrite, PCsrc, pc_en, illegal, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int hs_cycle = 0;

    mc_control_unit dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .EQ(EQ), .ALUctrl(ALUctrl), .ALUsrc(ALUsrc),
        .ImmOp(ImmOp), .rs1(rs1), .rs2(rs2), .rd(rd), .RegWrite(RegWrite),
        .PCsrc(PCsrc), .pc_en(pc_en), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic        legal;
        logic [2:0]  ctrl;
        logic        src;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wr;
        logic        br;
        logic        bne;
        logic        chk_rs2;
        logic        chk_rd;
    } exp_t;

    // Reference decode built from the instruction-set table
    function automatic exp_t model(input logic [31:0] ins);
        exp_t e;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic signed [11:0] iimm;
        logic signed [12:0] bimm;
        e = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        f7 = ins[31:25];
        iimm = ins[31:20];
        bimm = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e.rs1 = ins[19:15];
        if (op == 7'b0010011) begin
            e.src = 1'b1; e.imm = int'(iimm); e.wr = 1'b1;
            e.rd = ins[11:7]; e.chk_rd = 1'b1;
            if (f3 == 3'b000) begin e.legal = 1'b1; e.ctrl = 3'b000; end
            if (f3 == 3'b111) begin e.legal = 1'b1; e.ctrl = 3'b010; end
            if (f3 == 3'b110) begin e.legal = 1'b1; e.ctrl = 3'b011; end
`ifdef ALU_SLT_EN
            if (f3 == 3'b010) begin e.legal = 1'b1; e.ctrl = 3'b101; end
`endif
        end else if (op == 7'b0110011) begin
            e.wr = 1'b1; e.rd = ins[11:7]; e.rs2 = ins[24:20];
            e.chk_rd = 1'b1; e.chk_rs2 = 1'b1;
            if (f7 == 7'b0000000 && f3 == 3'b000) begin e.legal = 1'b1; e.ctrl = 3'b000; end
            if (f7 == 7'b0100000 && f3 == 3'b000) begin e.legal = 1'b1; e.ctrl = 3'b001; end
            if (f7 == 7'b0000000 && f3 == 3'b111) begin e.legal = 1'b1; e.ctrl = 3'b010; end
            if (f7 == 7'b0000000 && f3 == 3'b110) begin e.legal = 1'b1; e.ctrl = 3'b011; end
`ifdef ALU_SLT_EN
            if (f7 == 7'b0000000 && f3 == 3'b010) begin e.legal = 1'b1; e.ctrl = 3'b101; end
`endif
        end else if (op == 7'b1100011) begin
            e.br = 1'b1; e.bne = (f3 == 3'b001); e.ctrl = 3'b001;
            e.imm = int'(bimm); e.rs2 = ins[24:20]; e.chk_rs2 = 1'b1;
            e.legal = (f3 == 3'b000) || (f3 == 3'b001);
        end
        return e;
    endfunction

    // Random instruction of a chosen flavour
    function automatic logic [31:0] gen_instr(input int kind);
        logic [31:0] r;
        logic [2:0]  f3;
        r = $urandom;
        case (kind)
            0: begin
                case ($urandom_range(0, 3))
                    0: f3 = 3'b000; 1: f3 = 3'b111; 2: f3 = 3'b110; default: f3 = 3'b010;
                endcase
                return {r[31:15], f3, r[11:7], 7'b0010011};
            end
            1: begin
                case ($urandom_range(0, 4))
                    0: return {7'b0000000, r[24:15], 3'b000, r[11:7], 7'b0110011};
                    1: return {7'b0100000, r[24:15], 3'b000, r[11:7], 7'b0110011};
                    2: return {7'b0000000, r[24:15], 3'b111, r[11:7], 7'b0110011};
                    3: return {7'b0000000, r[24:15], 3'b110, r[11:7], 7'b0110011};
                    default: return {7'b0000000, r[24:15], 3'b010, r[11:7], 7'b0110011};
                endcase
            end
            2: return {r[31:15], 2'b00, r[12], r[11:7], 7'b1100011};
            3: return {r[31:15], 3'b001, r[11:7], 7'b0010011};
            4: return {r[31:25] | 7'b0000001, r[24:15], r[14:12], r[11:7], 7'b0110011};
            5: return {r[31:15], 3'b000, 5'd0, 7'b0010011};
            6: return {r[31:15], 1'b1, r[13:12], r[11:7], 7'b1100011};
            default: return r;
        endcase
    endfunction

    // Issue one instruction and check every cycle up to the following FETCH
    task automatic run_instr(input logic [31:0] ins, input logic eq);
        exp_t e;
        int   waited;
        e = model(ins);
        instr = ins;
        instr_valid = 1'b1;
        waited = 0;
        while (instr_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests++;
        if (instr_ready !== 1'b1) begin
            fails++;
            $display("FAIL ready_timeout ins=%h instr_ready=%b expected 1", ins, instr_ready);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clk);
        hs_cycle = cyc;
        instr_valid = 1'b0;
        instr = $urandom;
        EQ = !eq;
        // DECODE cycle
        tests++;
        if ({busy, instr_ready, illegal, pc_en, RegWrite, PCsrc} !== {1'b1, 1'b0, !e.legal, 3'b000}) begin
            fails++;
            $display("FAIL decode_flags ins=%h got busy/rdy/ill/pc/rw/pcs=%b expected %b", ins,
                     {busy, instr_ready, illegal, pc_en, RegWrite, PCsrc}, {1'b1, 1'b0, !e.legal, 3'b000});
        end
        if (!e.legal) begin
            @(negedge clk);
            tests++;
            if ({instr_ready, busy, illegal, pc_en, RegWrite, PCsrc} !== 6'b100000) begin
                fails++;
                $display("FAIL illegal_return ins=%h got rdy/busy/ill/pc/rw/pcs=%b expected 100000", ins,
                         {instr_ready, busy, illegal, pc_en, RegWrite, PCsrc});
            end
            return;
        end
        tests++;
        if ({ALUctrl, ALUsrc, ImmOp, rs1} !== {e.ctrl, e.src, e.imm, e.rs1} ||
            (e.chk_rs2 && rs2 !== e.rs2) || (e.chk_rd && rd !== e.rd)) begin
            fails++;
            $display("FAIL decode_ctrl ins=%h got ctrl=%b src=%b imm=%h rs1=%0d rs2=%0d rd=%0d expected ctrl=%b src=%b imm=%h rs1=%0d rs2=%0d rd=%0d",
                     ins, ALUctrl, ALUsrc, ImmOp, rs1, rs2, rd, e.ctrl, e.src, e.imm, e.rs1, e.rs2, e.rd);
        end
        // EXEC cycle
        @(negedge clk);
        EQ = eq;
        tests++;
        if ({busy, pc_en, RegWrite, PCsrc, illegal} !== 5'b10000) begin
            fails++;
            $display("FAIL exec_strobes ins=%h got busy/pc/rw/pcs/ill=%b expected 10000", ins,
                     {busy, pc_en, RegWrite, PCsrc, illegal});
        end
        // WB cycle
        @(negedge clk);
        EQ = !eq;
        tests++;
        if ({RegWrite, pc_en, PCsrc, illegal, busy} !==
            {e.wr && (e.rd != 5'd0), 1'b1, e.br && (e.bne ? !eq : eq), 1'b0, 1'b1}) begin
            fails++;
            $display("FAIL wb_strobes ins=%h eq=%b got rw/pc/pcs/ill/busy=%b expected %b", ins, eq,
                     {RegWrite, pc_en, PCsrc, illegal, busy},
                     {e.wr && (e.rd != 5'd0), 1'b1, e.br && (e.bne ? !eq : eq), 1'b0, 1'b1});
        end
        // Following FETCH cycle: strobes gone, controls still held
        @(negedge clk);
        tests++;
        if ({instr_ready, busy, RegWrite, pc_en, PCsrc, illegal} !== 6'b100000 ||
            {ALUctrl, ALUsrc, ImmOp} !== {e.ctrl, e.src, e.imm}) begin
            fails++;
            $display("FAIL fetch_after_wb ins=%h got rdy/busy/rw/pc/pcs/ill=%b ctrl=%b imm=%h expected 100000 ctrl=%b imm=%h",
                     ins, {instr_ready, busy, RegWrite, pc_en, PCsrc, illegal}, ALUctrl, ImmOp, e.ctrl, e.imm);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        instr = '0;
        EQ = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({instr_ready, busy, RegWrite, pc_en, PCsrc, illegal, ALUctrl, ALUsrc, ImmOp} !== {6'b100000, 36'd0}) begin
            fails++;
            $display("FAIL reset_state got rdy/busy/rw/pc/pcs/ill=%b ctrl=%b imm=%h expected 100000 ctrl=000 imm=0",
                     {instr_ready, busy, RegWrite, pc_en, PCsrc, illegal}, ALUctrl, ImmOp);
        end
        @(negedge clk);
        tests++;
        if ({instr_ready, busy, RegWrite, pc_en, illegal} !== 5'b10000) begin
            fails++;
            $display("FAIL after_reset got rdy/busy/rw/pc/ill=%b expected 10000",
                     {instr_ready, busy, RegWrite, pc_en, illegal});
        end
    endtask

    task automatic test_directed();
        run_instr(32'h00500093, 1'b0);  // addi x1,x0,5
        run_instr(32'h402081B3, 1'b1);  // sub x3,x1,x2
        run_instr(32'hFE009EE3, 1'b0);  // bne taken
        run_instr(32'hFE009EE3, 1'b1);  // bne not taken
        run_instr(32'hFE008EE3, 1'b1);  // beq taken
        run_instr(32'h0020A1B3, 1'b0);  // slt x3,x1,x2
        run_instr(32'h00500013, 1'b0);  // addi x0,x0,5
        run_instr(32'h00000000, 1'b0);  // all zeros: illegal
    endtask

    task automatic test_idle();
        instr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            tests++;
            if ({instr_ready, busy, pc_en, illegal} !== 4'b1000) begin
                fails++;
                $display("FAIL idle_hold cycle=%0d got rdy/busy/pc/ill=%b expected 1000", i,
                         {instr_ready, busy, pc_en, illegal});
            end
        end
    endtask

    task automatic test_reset_in_exec();
        instr = 32'h00700293;  // addi x5,x0,7
        instr_valid = 1'b1;
        @(negedge clk);        // accepted at the edge before this point: DECODE
        instr_valid = 1'b0;
        @(negedge clk);        // EXEC
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({instr_ready, busy, RegWrite, pc_en, PCsrc, illegal} !== 6'b100000) begin
            fails++;
            $display("FAIL reset_in_exec got rdy/busy/rw/pc/pcs/ill=%b expected 100000",
                     {instr_ready, busy, RegWrite, pc_en, PCsrc, illegal});
        end
        @(negedge clk);
        tests++;
        if ({instr_ready, busy, RegWrite, pc_en} !== 4'b1000) begin
            fails++;
            $display("FAIL reset_in_exec_next got rdy/busy/rw/pc=%b expected 1000",
                     {instr_ready, busy, RegWrite, pc_en});
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            instr_valid = 1'b0;
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_instr(gen_instr($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_back_to_back();
        int prev;
        run_instr(gen_instr(0), 1'b0);
        prev = hs_cycle;
        for (int n = 0; n < 10; n++) begin
            run_instr(gen_instr($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            tests++;
            if (hs_cycle - prev != 4) begin
                fails++;
                $display("FAIL back_to_back_interval n=%0d got %0d cycles expected 4", n, hs_cycle - prev);
            end
            prev = hs_cycle;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_idle();
        test_reset_in_exec();
        test_random();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
